// File: rtl/peak_freq_report.sv
// FFT peak-bin post-processor: bit-reverse, fold, bin-to-Hz multiply, stability filter, BCD.
// Outputs refresh only after STABLE_FRAMES consecutive agreeing frames.
module peak_freq_report #(
  parameter int unsigned HZ_PER_BIN_Q8 = 12000,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned BIN_TOL       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        detectdone,
  input  logic [9:0]  maxbin,
  output logic        busy,
  output logic [15:0] freq_hz,
  output logic [19:0] freq_bcd,
  output logic        freq_valid,
  output logic        new_freq
);

  localparam int unsigned BIN_W = 10;
  localparam int unsigned ACC_W = 26;
  localparam int unsigned HZ_W  = 16;
  localparam int unsigned BCD_W = 20;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ITR_W = 4;

  typedef enum logic [2:0] {
    IDLE, FOLD, MULT, ROUND, FILTER, BCD, DONE
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   cap;
  logic [BIN_W-1:0]   k;
  logic [BIN_W-1:0]   last_k;
  logic [CNT_W-1:0]   stable_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ITR_W-1:0]   iter;
  logic [HZ_W-1:0]    hz;
  logic [HZ_W-1:0]    hz_shift;
  logic [BCD_W-1:0]   bcd;

  logic [BIN_W-1:0]   k_rev;
  logic [BIN_W-1:0]   k_fold;
  logic [BIN_W-1:0]   k_diff;
  logic [CNT_W-1:0]   cnt_next;
  logic [ACC_W:0]     acc_rnd;
  logic [HZ_W-1:0]    hz_sat;
  logic [BCD_W-1:0]   bcd_adj;

  // Restore linear bin order and fold the upper half-spectrum onto the lower half.
  always_comb begin
    k_rev = '0;
    for (int i = 0; i < int'(BIN_W); i++) k_rev[i] = cap[int'(BIN_W) - 1 - i];
    k_fold = k_rev;
    if (k_rev > BIN_W'(512)) k_fold = BIN_W'(11'd1024 - {1'b0, k_rev});
  end

  // Round Q8 accumulator to whole Hz, saturating at 16 bits.
  always_comb begin
    acc_rnd = {1'b0, acc} + (ACC_W + 1)'(128);
    hz_sat  = acc_rnd[HZ_W+7:8];
    if (|acc_rnd[ACC_W:HZ_W+8]) hz_sat = '1;
  end

  // Agreement test against the previous frame's bin.
  always_comb begin
    k_diff   = (k >= last_k) ? (k - last_k) : (last_k - k);
    cnt_next = CNT_W'(1);
    if (k_diff <= BIN_W'(BIN_TOL)) begin
      if (stable_cnt >= CNT_W'(STABLE_FRAMES)) cnt_next = CNT_W'(STABLE_FRAMES);
      else                                     cnt_next = stable_cnt + CNT_W'(1);
    end
  end

  // Double-dabble correction: add 3 to every BCD digit >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 5; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cap        <= '0;
      k          <= '0;
      last_k     <= '0;
      stable_cnt <= '0;
      acc        <= '0;
      iter       <= '0;
      hz         <= '0;
      hz_shift   <= '0;
      bcd        <= '0;
      busy       <= 1'b0;
      freq_hz    <= '0;
      freq_bcd   <= '0;
      freq_valid <= 1'b0;
      new_freq   <= 1'b0;
    end else begin
      new_freq <= 1'b0;
      unique case (state)
        IDLE: begin
          if (detectdone) begin
            cap   <= maxbin;
            busy  <= 1'b1;
            state <= FOLD;
          end
        end
        FOLD: begin
          k     <= k_fold;
          acc   <= '0;
          iter  <= '0;
          state <= MULT;
        end
        MULT: begin
          if (k[iter]) acc <= acc + (ACC_W'(HZ_PER_BIN_Q8) << iter);
          if (iter == ITR_W'(BIN_W - 1)) state <= ROUND;
          else                           iter  <= iter + ITR_W'(1);
        end
        ROUND: begin
          hz    <= hz_sat;
          state <= FILTER;
        end
        FILTER: begin
          last_k     <= k;
          stable_cnt <= cnt_next;
          if (cnt_next >= CNT_W'(STABLE_FRAMES)) begin
            hz_shift <= hz;
            bcd      <= '0;
            iter     <= '0;
            state    <= BCD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        BCD: begin
          bcd      <= {bcd_adj[BCD_W-2:0], hz_shift[HZ_W-1]};
          hz_shift <= hz_shift << 1;
          if (iter == ITR_W'(HZ_W - 1)) state <= DONE;
          else                          iter  <= iter + ITR_W'(1);
        end
        DONE: begin
          freq_hz    <= hz;
          freq_bcd   <= bcd;
          freq_valid <= 1'b1;
          new_freq   <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_freq_report.sv
// Directed self-checking bench for peak_freq_report.
`timescale 1ns/1ps
module tb_peak_freq_report;

  logic        clk = 1'b0;
  logic        reset;
  logic        detectdone;
  logic [9:0]  maxbin;
  logic        busy;
  logic [15:0] freq_hz;
  logic [19:0] freq_bcd;
  logic        freq_valid;
  logic        new_freq;

  int checks = 0;
  int errors = 0;

  peak_freq_report dut (
    .clk        (clk),
    .reset      (reset),
    .detectdone (detectdone),
    .maxbin     (maxbin),
    .busy       (busy),
    .freq_hz    (freq_hz),
    .freq_bcd   (freq_bcd),
    .freq_valid (freq_valid),
    .new_freq   (new_freq)
  );

  always #10 clk = ~clk;

  // One frame: pulse at E0, then watch 34 cycles for the new_freq pulse.
  task automatic send_frame(input logic [9:0] mb, input bit upd,
                            input logic [15:0] ehz, input logic [19:0] ebcd,
                            input string name);
    int first;
    int pulses;
    first  = 0;
    pulses = 0;
    @(negedge clk);
    maxbin     = mb;
    detectdone = 1'b1;
    @(posedge clk); #1;
    detectdone = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_capture: got %b expected 1", name, busy);
    end
    for (int n = 1; n <= 34; n++) begin
      @(posedge clk); #1;
      if (new_freq === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    checks++;
    if (pulses !== (upd ? 1 : 0) || first !== (upd ? 30 : 0)) begin
      errors++;
      $display("FAIL %s new_freq: got %0d pulses first at cycle %0d expected %0d at %0d",
               name, pulses, first, upd ? 1 : 0, upd ? 30 : 0);
    end
    checks++;
    if (freq_hz !== ehz) begin
      errors++;
      $display("FAIL %s freq_hz: got %0d expected %0d", name, freq_hz, ehz);
    end
    checks++;
    if (freq_bcd !== ebcd) begin
      errors++;
      $display("FAIL %s freq_bcd: got %h expected %h", name, freq_bcd, ebcd);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end: got %b expected 0", name, busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 5;
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (freq_hz !== 16'd0)   begin errors++; $display("FAIL reset freq_hz: got %0d expected 0", freq_hz); end
    if (freq_bcd !== 20'h0)  begin errors++; $display("FAIL reset freq_bcd: got %h expected 0", freq_bcd); end
    if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset freq_valid: got %b expected 0", freq_valid); end
    if (new_freq !== 1'b0)   begin errors++; $display("FAIL reset new_freq: got %b expected 0", new_freq); end
  endtask

  // maxbin 8 -> k=64 -> 64*46.875 = 3000 Hz.
  task automatic test_basic();
    send_frame(10'd8, 1'b0, 16'd0, 20'h00000, "basic1");
    checks++;
    if (freq_valid !== 1'b0) begin errors++; $display("FAIL basic valid_early: got %b expected 0", freq_valid); end
    send_frame(10'd8, 1'b0, 16'd0, 20'h00000, "basic2");
    send_frame(10'd8, 1'b1, 16'd3000, 20'h03000, "basic3");
    checks++;
    if (freq_valid !== 1'b1) begin errors++; $display("FAIL basic valid: got %b expected 1", freq_valid); end
  endtask

  // maxbin 15 -> k=960 folds to 64 (already stable); maxbin 1 -> k=512 kept.
  task automatic test_fold();
    send_frame(10'd15, 1'b1, 16'd3000, 20'h03000, "fold960_1");
    send_frame(10'd15, 1'b1, 16'd3000, 20'h03000, "fold960_2");
    send_frame(10'd15, 1'b1, 16'd3000, 20'h03000, "fold960_3");
    send_frame(10'd1, 1'b0, 16'd3000, 20'h03000, "k512_1");
    send_frame(10'd1, 1'b0, 16'd3000, 20'h03000, "k512_2");
    send_frame(10'd1, 1'b1, 16'd24000, 20'h24000, "k512_3");
  endtask

  // maxbin 512 -> k=1 -> 46.875 rounds to 47.
  task automatic test_rounding();
    send_frame(10'd512, 1'b0, 16'd24000, 20'h24000, "round1");
    send_frame(10'd512, 1'b0, 16'd24000, 20'h24000, "round2");
    send_frame(10'd512, 1'b1, 16'd47, 20'h00047, "round3");
  endtask

  // k = 64, 70, 64 never agrees; maxbin 392 -> k=70.
  task automatic test_stability_reject();
    send_frame(10'd8,   1'b0, 16'd47, 20'h00047, "rej64a");
    send_frame(10'd392, 1'b0, 16'd47, 20'h00047, "rej70");
    send_frame(10'd8,   1'b0, 16'd47, 20'h00047, "rej64b");
  endtask

  // k = 1 breaks the run, then 64, 65, 64 agree within tolerance; maxbin 520 -> k=65.
  task automatic test_stability_accept();
    send_frame(10'd512, 1'b0, 16'd47, 20'h00047, "acc_k1");
    send_frame(10'd8,   1'b0, 16'd47, 20'h00047, "acc64a");
    send_frame(10'd520, 1'b0, 16'd47, 20'h00047, "acc65");
    send_frame(10'd8,   1'b1, 16'd3000, 20'h03000, "acc64b");
  endtask

  // Re-pulses at E5 and E30 are dropped; E31 is captured and updates at E61.
  task automatic test_back_to_back();
    int pulses;
    int last;
    pulses = 0;
    last   = 0;
    @(negedge clk);
    maxbin     = 10'd8;
    detectdone = 1'b1;
    @(posedge clk); #1;
    detectdone = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      if (n == 5 || n == 30 || n == 31) begin
        detectdone = 1'b1;
        maxbin     = (n == 31) ? 10'd8 : 10'd1;
      end
      @(posedge clk); #1;
      detectdone = 1'b0;
      if (new_freq === 1'b1) begin
        pulses++;
        last = n;
      end
      if (n == 30) begin
        checks++;
        if (new_freq !== 1'b1 || freq_hz !== 16'd3000) begin
          errors++;
          $display("FAIL b2b first_update: got new_freq=%b hz=%0d expected 1 and 3000", new_freq, freq_hz);
        end
      end
      if (n == 31) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b capture_e31: got busy=%b expected 1", busy);
        end
      end
    end
    checks++;
    if (pulses !== 2 || last !== 61) begin
      errors++;
      $display("FAIL b2b pulses: got %0d last at %0d expected 2 last at 61", pulses, last);
    end
    checks++;
    if (freq_hz !== 16'd3000 || freq_bcd !== 20'h03000) begin
      errors++;
      $display("FAIL b2b final: got hz=%0d bcd=%h expected 3000 03000", freq_hz, freq_bcd);
    end
  endtask

  // Reset sampled at E20 (inside BCD) aborts the frame.
  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    maxbin     = 10'd8;
    detectdone = 1'b1;
    @(posedge clk); #1;
    detectdone = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || freq_hz !== 16'd0 || freq_bcd !== 20'h0 || freq_valid !== 1'b0 || new_freq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: got busy=%b hz=%0d bcd=%h valid=%b new=%b expected all 0",
               busy, freq_hz, freq_bcd, freq_valid, new_freq);
    end
    repeat (15) begin
      @(posedge clk); #1;
      if (new_freq === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid no_update: got %0d pulses expected 0", pulses);
    end
    send_frame(10'd8, 1'b0, 16'd0, 20'h00000, "post_rst1");
    send_frame(10'd8, 1'b0, 16'd0, 20'h00000, "post_rst2");
    send_frame(10'd8, 1'b1, 16'd3000, 20'h03000, "post_rst3");
  endtask

  // k = 0 agrees with the reset value of last_k from the first frame.
  task automatic test_dc();
    do_reset();
    send_frame(10'd0, 1'b0, 16'd0, 20'h00000, "dc1");
    send_frame(10'd0, 1'b0, 16'd0, 20'h00000, "dc2");
    checks++;
    if (freq_valid !== 1'b0) begin errors++; $display("FAIL dc valid_early: got %b expected 0", freq_valid); end
    send_frame(10'd0, 1'b1, 16'd0, 20'h00000, "dc3");
    checks++;
    if (freq_valid !== 1'b1) begin errors++; $display("FAIL dc valid: got %b expected 1", freq_valid); end
  endtask

  initial begin
    reset      = 1'b1;
    detectdone = 1'b0;
    maxbin     = '0;
    test_reset();
    test_basic();
    test_fold();
    test_rounding();
    test_stability_reject();
    test_stability_accept();
    test_back_to_back();
    test_reset_mid();
    test_dc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
